traffic_sensor_avg: RTL and testbench
=====================================

TRAFFIC_SENSOR_AVG -- requirements
Module: traffic_sensor_avg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the vehicle-count sample width.
REQ-002 The block SHALL have parameter LOG_DEPTH, default 2, where window depth DEPTH = 2**LOG_DEPTH (valid range 1..6).
REQ-003 The block SHALL have parameter NUM_LANES, default 4, the number of independent sensor lanes (range 1..16).
REQ-004 The block SHALL have parameter THRESH, default 12, the congestion threshold compared against the lane average.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; clock and reset SHALL be the first two ports in the port list.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port sample_valid, input, 1 bit: new_data is presented for lane_sel this cycle.
REQ-009 The block SHALL have port lane_sel, input, LW = max(1,clog2(NUM_LANES)) bits: target lane of the sample.
REQ-010 The block SHALL have port new_data, input, DATA_W bits: vehicle count sample.
REQ-011 The block SHALL have port clr_valid, input, 1 bit: request to clear lane clr_lane.
REQ-012 The block SHALL have port clr_lane, input, LW bits: lane to clear.
REQ-013 The block SHALL have port avg_valid, output, 1 bit: one-cycle pulse marking updated result outputs.
REQ-014 The block SHALL have port avg_lane, output, LW bits: lane to which the result outputs refer.
REQ-015 The block SHALL have port sum, output, DATA_W+LOG_DEPTH bits: window sum of avg_lane.
REQ-016 The block SHALL have port mov_avg, output, DATA_W bits: sum >> LOG_DEPTH, truncated.
REQ-017 The block SHALL have port window_full, output, 1 bit: avg_lane has received at least DEPTH samples since its last reset or clear.
REQ-018 The block SHALL have port congested, output, NUM_LANES bits: per lane, registered flag mov_avg >= THRESH.
REQ-019 The block SHALL have port lane_err, output, 1 bit: one-cycle pulse when sample_valid or clr_valid names a lane >= NUM_LANES.

Function
REQ-020 The block SHALL hold a per-lane circular buffer of DEPTH entries, a per-lane write pointer, a per-lane running sum and a per-lane fill count saturating at DEPTH.
REQ-021 On an accepted sample the block SHALL, at the same edge, update sum_new = sum_old - buf[wr_ptr] + new_data, write new_data into buf[wr_ptr], and advance wr_ptr, wrapping from DEPTH-1 to 0.
REQ-022 The sum SHALL be computed at full width DATA_W+LOG_DEPTH and SHALL never overflow or saturate.
REQ-023 The result outputs (avg_valid, avg_lane, sum, mov_avg, window_full) SHALL be registered, with avg_valid high exactly in the cycle following the accepting edge (latency 1).
REQ-024 When no sample is accepted, avg_valid SHALL be 0 and the other result outputs SHALL hold their previous values.
REQ-025 congested[lane] SHALL update in the same cycle as that lane's avg_valid; other lanes' bits SHALL hold.
REQ-026 Before the window fills, mov_avg SHALL still equal sum >> LOG_DEPTH, with empty slots counted as 0.
REQ-027 A clear SHALL zero the buffer, sum, wr_ptr, fill count and congested bit of the named lane in one cycle, and SHALL NOT produce avg_valid.
REQ-028 When a clear and a sample target the same lane in the same cycle, the clear SHALL win and the sample SHALL be dropped.
REQ-029 When a clear and a sample target different lanes in the same cycle, both SHALL take effect.
REQ-030 An out-of-range lane SHALL cause no state change and SHALL pulse lane_err in the next cycle.
REQ-031 The block SHALL accept a sample every cycle with no backpressure.

Reset
REQ-032 When reset is high, reset SHALL take priority over sample_valid and clr_valid.
REQ-033 Reset SHALL zero all buffers, sums, pointers, fill counts and every output (avg_valid, avg_lane, sum, mov_avg, window_full, congested, lane_err) at the next edge.

Verification (defaults unless stated)
REQ-034 The bench SHALL check: after reset, lane 0 samples 5,10,20,15 on consecutive cycles -> sum 5,15,35,50; mov_avg 1,3,8,12; window_full only on the 4th result; congested[0] set on the 4th result.
REQ-035 The bench SHALL check: a 5th lane-0 sample of 40 -> sum 85, mov_avg 21, buf slot 0 overwritten (wrap).
REQ-036 The bench SHALL check: four lane-1 samples of 255 interleaved with lane-0 traffic -> lane-1 sum 1020, mov_avg 255, and lane-0 results unaffected.
REQ-037 The bench SHALL check: clear lane 0 together with a sample to lane 0 -> no avg_valid; the next lane-0 sample of 8 -> sum 8, mov_avg 2, congested[0] = 0.
REQ-038 The bench SHALL check, with NUM_LANES = 3: sample_valid with lane_sel = 3 -> lane_err pulse 1 cycle later, no avg_valid, all sums unchanged.
REQ-039 The bench SHALL check: reset asserted in the same cycle as sample_valid mid-stream -> sample ignored and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/traffic_sensor_avg.sv
// Per-lane moving-window vehicle-count averager with a congestion flag per lane.
// Latency: one cycle from accepting edge to avg_valid/result outputs; lane_err also one cycle.
// Backpressure: none; a sample and a clear may be presented every cycle.
module traffic_sensor_avg #(
   parameter int DATA_W    = 8,
   parameter int LOG_DEPTH = 2,
   parameter int NUM_LANES = 4,
   parameter int THRESH    = 12,
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
   localparam int SW = DATA_W + LOG_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_valid,
   input  logic [LW-1:0]        lane_sel,
   input  logic [DATA_W-1:0]    new_data,
   input  logic                 clr_valid,
   input  logic [LW-1:0]        clr_lane,
   output logic                 avg_valid,
   output logic [LW-1:0]        avg_lane,
   output logic [SW-1:0]        sum,
   output logic [DATA_W-1:0]    mov_avg,
   output logic                 window_full,
   output logic [NUM_LANES-1:0] congested,
   output logic                 lane_err
);

   localparam int DEPTH = 2 ** LOG_DEPTH;
   localparam int FW    = LOG_DEPTH + 1;
   localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);
   localparam logic [LW:0]   NL_C    = (LW + 1)'(NUM_LANES);
   localparam logic [SW-1:0] THR_C   = SW'(THRESH);

   // Per-lane window state
   logic [DEPTH-1:0][DATA_W-1:0] win_q  [NUM_LANES];
   logic [DEPTH-1:0][DATA_W-1:0] win_d  [NUM_LANES];
   logic [LOG_DEPTH-1:0]         ptr_q  [NUM_LANES];
   logic [LOG_DEPTH-1:0]         ptr_d  [NUM_LANES];
   logic [SW-1:0]                lsum_q [NUM_LANES];
   logic [SW-1:0]                lsum_d [NUM_LANES];
   logic [FW-1:0]                fill_q [NUM_LANES];
   logic [FW-1:0]                fill_d [NUM_LANES];
   logic [NUM_LANES-1:0]         cong_q, cong_d;

   // Registered result outputs
   logic                         avg_valid_q, avg_valid_d;
   logic [LW-1:0]                avg_lane_q, avg_lane_d;
   logic [SW-1:0]                sum_q, sum_d;
   logic [DATA_W-1:0]            mov_avg_q, mov_avg_d;
   logic                         wfull_q, wfull_d;
   logic                         lane_err_q, lane_err_d;

   // Combinational temporaries
   logic                         smp_in_rng, clr_in_rng;
   logic                         smp_acc, clr_acc;
   logic [DATA_W-1:0]            old_val;
   logic [SW-1:0]                new_sum;
   logic [FW-1:0]                fill_nxt;
   logic [DATA_W-1:0]            new_avg;

   // Next-state: sample update first, then a clear overrides its own lane
   always_comb begin
      win_d       = win_q;
      ptr_d       = ptr_q;
      lsum_d      = lsum_q;
      fill_d      = fill_q;
      cong_d      = cong_q;
      avg_valid_d = 1'b0;
      avg_lane_d  = avg_lane_q;
      sum_d       = sum_q;
      mov_avg_d   = mov_avg_q;
      wfull_d     = wfull_q;
      old_val     = '0;
      new_sum     = '0;
      fill_nxt    = '0;
      new_avg     = '0;

      smp_in_rng = ({1'b0, lane_sel} < NL_C);
      clr_in_rng = ({1'b0, clr_lane} < NL_C);
      clr_acc    = clr_valid && clr_in_rng;
      // A clear to the same lane wins; the colliding sample is dropped
      smp_acc    = sample_valid && smp_in_rng && !(clr_acc && (clr_lane == lane_sel));
      lane_err_d = (sample_valid && !smp_in_rng) || (clr_valid && !clr_in_rng);

      if (smp_acc) begin
         old_val  = win_q[lane_sel][ptr_q[lane_sel]];
         // Running sum stays exact: it always contains old_val, so no underflow
         new_sum  = lsum_q[lane_sel] - SW'(old_val) + SW'(new_data);
         new_avg  = DATA_W'(new_sum >> LOG_DEPTH);
         fill_nxt = (fill_q[lane_sel] == DEPTH_C) ? DEPTH_C : fill_q[lane_sel] + 1'b1;

         win_d[lane_sel][ptr_q[lane_sel]] = new_data;
         ptr_d[lane_sel]  = ptr_q[lane_sel] + 1'b1;
         lsum_d[lane_sel] = new_sum;
         fill_d[lane_sel] = fill_nxt;
         cong_d[lane_sel] = (new_sum >> LOG_DEPTH) >= THR_C;

         avg_valid_d = 1'b1;
         avg_lane_d  = lane_sel;
         sum_d       = new_sum;
         mov_avg_d   = new_avg;
         wfull_d     = (fill_nxt == DEPTH_C);
      end

      if (clr_acc) begin
         win_d[clr_lane]  = '0;
         ptr_d[clr_lane]  = '0;
         lsum_d[clr_lane] = '0;
         fill_d[clr_lane] = '0;
         cong_d[clr_lane] = 1'b0;
      end
   end

   // State register with synchronous reset taking priority over all requests
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            win_q[i]  <= '0;
            ptr_q[i]  <= '0;
            lsum_q[i] <= '0;
            fill_q[i] <= '0;
         end
         cong_q      <= '0;
         avg_valid_q <= 1'b0;
         avg_lane_q  <= '0;
         sum_q       <= '0;
         mov_avg_q   <= '0;
         wfull_q     <= 1'b0;
         lane_err_q  <= 1'b0;
      end else begin
         win_q       <= win_d;
         ptr_q       <= ptr_d;
         lsum_q      <= lsum_d;
         fill_q      <= fill_d;
         cong_q      <= cong_d;
         avg_valid_q <= avg_valid_d;
         avg_lane_q  <= avg_lane_d;
         sum_q       <= sum_d;
         mov_avg_q   <= mov_avg_d;
         wfull_q     <= wfull_d;
         lane_err_q  <= lane_err_d;
      end
   end

   assign avg_valid   = avg_valid_q;
   assign avg_lane    = avg_lane_q;
   assign sum         = sum_q;
   assign mov_avg     = mov_avg_q;
   assign window_full = wfull_q;
   assign congested   = cong_q;
   assign lane_err    = lane_err_q;

endmodule

// File: tb/tb_traffic_sensor_avg.sv
// Bench for traffic_sensor_avg with three lanes (lane 3 is out of range).
// Directed vector table plus reset corner, then random traffic against a window model.
// The DUT never backpressures, so inputs are driven every cycle.
module tb_traffic_sensor_avg;

   logic       clk;
   logic       reset;
   logic       sample_valid;
   logic [1:0] lane_sel;
   logic [7:0] new_data;
   logic       clr_valid;
   logic [1:0] clr_lane;
   logic       avg_valid;
   logic [1:0] avg_lane;
   logic [9:0] sum;
   logic [7:0] mov_avg;
   logic       window_full;
   logic [2:0] congested;
   logic       lane_err;

   int n_cmp = 0;
   int n_err = 0;

   traffic_sensor_avg #(
      .DATA_W(8), .LOG_DEPTH(2), .NUM_LANES(3), .THRESH(12)
   ) dut (
      .clk(clk), .reset(reset),
      .sample_valid(sample_valid), .lane_sel(lane_sel), .new_data(new_data),
      .clr_valid(clr_valid), .clr_lane(clr_lane),
      .avg_valid(avg_valid), .avg_lane(avg_lane), .sum(sum), .mov_avg(mov_avg),
      .window_full(window_full), .congested(congested), .lane_err(lane_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sv;
      logic [1:0] lane;
      logic [7:0] data;
      logic       cv;
      logic [1:0] cl;
      logic       e_vld;
      logic [1:0] e_lane;
      logic [9:0] e_sum;
      logic [7:0] e_avg;
      logic       e_full;
      logic [2:0] e_cong;
      logic       e_err;
   } vec_t;

   vec_t vt[$];

   task automatic addv(input logic sv, input logic [1:0] lane, input logic [7:0] data,
                       input logic cv, input logic [1:0] cl,
                       input logic e_vld, input logic [1:0] e_lane, input logic [9:0] e_sum,
                       input logic [7:0] e_avg, input logic e_full, input logic [2:0] e_cong,
                       input logic e_err);
      vec_t v;
      v.sv = sv; v.lane = lane; v.data = data; v.cv = cv; v.cl = cl;
      v.e_vld = e_vld; v.e_lane = e_lane; v.e_sum = e_sum; v.e_avg = e_avg;
      v.e_full = e_full; v.e_cong = e_cong; v.e_err = e_err;
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_vld, input logic [1:0] e_lane,
                            input logic [9:0] e_sum, input logic [7:0] e_avg,
                            input logic e_full, input logic [2:0] e_cong, input logic e_err);
      chk({tag, ".avg_valid"},   32'(avg_valid),   32'(e_vld));
      chk({tag, ".avg_lane"},    32'(avg_lane),    32'(e_lane));
      chk({tag, ".sum"},         32'(sum),         32'(e_sum));
      chk({tag, ".mov_avg"},     32'(mov_avg),     32'(e_avg));
      chk({tag, ".window_full"}, 32'(window_full), 32'(e_full));
      chk({tag, ".congested"},   32'(congested),   32'(e_cong));
      chk({tag, ".lane_err"},    32'(lane_err),    32'(e_err));
   endtask

   // Apply one cycle of inputs; outputs are examined 1 time unit after the edge
   task automatic drive(input logic rst, input logic sv, input logic [1:0] lane,
                        input logic [7:0] data, input logic cv, input logic [1:0] cl);
      reset = rst; sample_valid = sv; lane_sel = lane; new_data = data;
      clr_valid = cv; clr_lane = cl;
      @(posedge clk);
      #1;
   endtask

   // Reference model: each lane's window is simply the list of its most recent samples
   int unsigned mq [3][$];
   logic        m_vld, m_full, m_err;
   logic [1:0]  m_lane;
   logic [9:0]  m_sum;
   logic [7:0]  m_avg;
   logic [2:0]  m_cong;

   task automatic model_reset();
      for (int l = 0; l < 3; l++) mq[l].delete();
      m_vld = 0; m_lane = 0; m_sum = 0; m_avg = 0; m_full = 0; m_cong = 0; m_err = 0;
   endtask

   task automatic model_step(input logic sv, input int lane, input int unsigned data,
                             input logic cv, input int cl);
      int unsigned total;
      bit clr_ok;
      bit smp_ok;
      clr_ok = cv && (cl < 3);
      smp_ok = sv && (lane < 3) && !(clr_ok && cl == lane);
      m_err  = (sv && lane >= 3) || (cv && cl >= 3);
      m_vld  = smp_ok;
      if (smp_ok) begin
         mq[lane].push_back(data);
         if (mq[lane].size() > 4) void'(mq[lane].pop_front());
         total = 0;
         foreach (mq[lane][k]) total += mq[lane][k];
         m_lane = 2'(lane);
         m_sum  = 10'(total);
         m_avg  = 8'(total / 4);
         m_full = (mq[lane].size() == 4);
         m_cong[lane] = (total / 4) >= 12;
      end
      if (clr_ok) begin
         mq[cl].delete();
         m_cong[cl] = 1'b0;
      end
   endtask

   initial begin
      // Directed table: sv lane data cv cl | vld lane sum avg full cong err
      addv(1, 0,   5, 0, 0,  1, 0,    5,   1, 0, 3'b000, 0);
      addv(1, 0,  10, 0, 0,  1, 0,   15,   3, 0, 3'b000, 0);
      addv(1, 0,  20, 0, 0,  1, 0,   35,   8, 0, 3'b000, 0);
      addv(1, 0,  15, 0, 0,  1, 0,   50,  12, 1, 3'b001, 0);
      addv(1, 0,  40, 0, 0,  1, 0,   85,  21, 1, 3'b001, 0);
      addv(1, 1, 255, 0, 0,  1, 1,  255,  63, 0, 3'b011, 0);
      addv(1, 0,   0, 0, 0,  1, 0,   75,  18, 1, 3'b011, 0);
      addv(1, 1, 255, 0, 0,  1, 1,  510, 127, 0, 3'b011, 0);
      addv(1, 0,   0, 0, 0,  1, 0,   55,  13, 1, 3'b011, 0);
      addv(1, 1, 255, 0, 0,  1, 1,  765, 191, 0, 3'b011, 0);
      addv(1, 0,  30, 0, 0,  1, 0,   70,  17, 1, 3'b011, 0);
      addv(1, 1, 255, 0, 0,  1, 1, 1020, 255, 1, 3'b011, 0);
      addv(1, 0,  99, 1, 0,  0, 1, 1020, 255, 1, 3'b010, 0);
      addv(1, 0,   8, 0, 0,  1, 0,    8,   2, 0, 3'b010, 0);
      addv(1, 3,  77, 0, 0,  0, 0,    8,   2, 0, 3'b010, 1);
      addv(0, 0,   0, 0, 0,  0, 0,    8,   2, 0, 3'b010, 0);
      addv(1, 0,   4, 0, 0,  1, 0,   12,   3, 0, 3'b010, 0);
      addv(1, 1,   0, 0, 0,  1, 1,  765, 191, 1, 3'b010, 0);
      addv(1, 0,   4, 1, 1,  1, 0,   16,   4, 0, 3'b000, 0);
      addv(0, 0,   0, 1, 3,  0, 0,   16,   4, 0, 3'b000, 1);
      addv(1, 1,   7, 0, 0,  1, 1,    7,   1, 0, 3'b000, 0);

      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      check_all("reset", 0, 0, 0, 0, 0, 3'b000, 0);
      drive(0, 0, 0, 0, 0, 0);

      foreach (vt[i]) begin
         drive(0, vt[i].sv, vt[i].lane, vt[i].data, vt[i].cv, vt[i].cl);
         check_all($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_lane, vt[i].e_sum,
                   vt[i].e_avg, vt[i].e_full, vt[i].e_cong, vt[i].e_err);
      end

      // Reset in the same cycle as a sample mid-stream: sample ignored, all outputs zero
      drive(1, 1, 1, 50, 0, 0);
      check_all("rst_mid", 0, 0, 0, 0, 0, 3'b000, 0);
      drive(0, 1, 1, 3, 0, 0);
      check_all("post_rst", 1, 1, 3, 0, 0, 3'b000, 0);

      // Random traffic against the window model
      drive(1, 0, 0, 0, 0, 0);
      model_reset();
      check_all("rnd_reset", m_vld, m_lane, m_sum, m_avg, m_full, m_cong, m_err);
      for (int c = 0; c < 600; c++) begin
         logic       sv, cv;
         logic [1:0] ln, cl;
         logic [7:0] dt;
         sv = ($urandom_range(0, 3) != 0);
         ln = 2'($urandom_range(0, 3));
         dt = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
         cv = ($urandom_range(0, 9) == 0);
         cl = 2'($urandom_range(0, 3));
         drive(0, sv, ln, dt, cv, cl);
         model_step(sv, int'(ln), int'(dt), cv, int'(cl));
         check_all($sformatf("rnd%0d", c), m_vld, m_lane, m_sum, m_avg, m_full, m_cong, m_err);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
